// File: rtl/cs_window_buffer.sv
// cs_window_buffer
// Upstream stage of the CS computational core. Collects a serial stream of
// unsigned samples into a sliding window of the last DEPTH samples, keeps an
// exact running sum, and hands each complete window to the core over a
// valid/ready handshake together with a window index.
//
// Ports:
//   clk        clock, rising-edge active
//   reset      asynchronous, active-high reset
//   flush      synchronous clear of window, sum and fill count (index kept)
//   in_valid   in_data holds a sample
//   in_data    sample value, unsigned, DW bits
//   in_ready   a sample can be accepted this cycle
//   win_valid  win_data / win_sum / win_idx hold a complete window
//   win_ready  consumer takes the window this cycle
//   win_data   window contents; slice k is the k-th oldest, slice DEPTH-1 newest
//   win_sum    exact unsigned sum of all DEPTH slots
//   win_idx    count of windows emitted before this one, mod 2^16
//   win_min    (CS_WINDOW_MINMAX_EN only) minimum sample of the window
//   win_max    (CS_WINDOW_MINMAX_EN only) maximum sample of the window
//
// Optional feature macro: CS_WINDOW_MINMAX_EN adds the win_min/win_max outputs.
module cs_window_buffer #(
  parameter int DW    = 8,
  parameter int DEPTH = 9,
  parameter int SUMW  = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  input  logic [DW-1:0]       in_data,
  output logic                in_ready,
  output logic                win_valid,
  input  logic                win_ready,
  output logic [DEPTH*DW-1:0] win_data,
  output logic [SUMW-1:0]     win_sum,
`ifdef CS_WINDOW_MINMAX_EN
  output logic [DW-1:0]       win_min,
  output logic [DW-1:0]       win_max,
`endif
  output logic [15:0]         win_idx
);

  localparam int FW = $clog2(DEPTH + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(DEPTH);

  // Fill count saturates at DEPTH: once full, every accept replaces the oldest.
  function automatic logic [FW-1:0] fill_sat_inc(input logic [FW-1:0] f);
    return (f == FILL_FULL) ? FILL_FULL : f + FW'(1);
  endfunction

  // Add and subtract in one expression so the sum never overflows mid-update.
  function automatic logic [SUMW-1:0] sum_update(input logic [SUMW-1:0] s,
                                                 input logic [DW-1:0]   add,
                                                 input logic [DW-1:0]   sub,
                                                 input logic            full);
    logic [SUMW-1:0] sub_ext;
    sub_ext = full ? SUMW'(sub) : '0;
    return s + SUMW'(add) - sub_ext;
  endfunction

  logic [DW-1:0]   slot [DEPTH];
  logic [DW-1:0]   win_nxt [DEPTH];
  logic [FW-1:0]   fill;
  logic [FW-1:0]   fill_nxt;
  logic [SUMW-1:0] sum_nxt;
  logic            accept;
  logic            consume;
  logic            full;

  assign in_ready = !win_valid || win_ready;
  assign accept   = in_valid && in_ready;
  assign consume  = win_valid && win_ready;
  assign full     = (fill == FILL_FULL);
  assign fill_nxt = fill_sat_inc(fill);
  assign sum_nxt  = sum_update(win_sum, in_data, slot[0], full);

  // Window as it will look after an accept this cycle.
  always_comb begin
    for (int k = 0; k < DEPTH - 1; k++) begin
      win_nxt[k] = slot[k + 1];
    end
    win_nxt[DEPTH-1] = in_data;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_pack
    assign win_data[g*DW +: DW] = slot[g];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) slot[k] <= '0;
      win_sum   <= '0;
      fill      <= '0;
      win_valid <= 1'b0;
      win_idx   <= '0;
    end else if (flush) begin
      // Flush wins over a coincident accept and consume; the index is kept.
      for (int k = 0; k < DEPTH; k++) slot[k] <= '0;
      win_sum   <= '0;
      fill      <= '0;
      win_valid <= 1'b0;
    end else begin
      if (consume) win_idx <= win_idx + 16'd1;
      if (accept) begin
        for (int k = 0; k < DEPTH; k++) slot[k] <= win_nxt[k];
        win_sum   <= sum_nxt;
        fill      <= fill_nxt;
        // An accept can only happen with the old window gone or being taken,
        // so valid simply tracks whether the new window is complete.
        win_valid <= (fill_nxt == FILL_FULL);
      end else if (consume) begin
        win_valid <= 1'b0;
      end
    end
  end

`ifdef CS_WINDOW_MINMAX_EN
  logic [DW-1:0] min_nxt;
  logic [DW-1:0] max_nxt;

  always_comb begin
    min_nxt = win_nxt[0];
    max_nxt = win_nxt[0];
    for (int k = 1; k < DEPTH; k++) begin
      if (win_nxt[k] < min_nxt) min_nxt = win_nxt[k];
      if (win_nxt[k] > max_nxt) max_nxt = win_nxt[k];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_min <= '0;
      win_max <= '0;
    end else if (flush) begin
      win_min <= '0;
      win_max <= '0;
    end else if (accept) begin
      win_min <= min_nxt;
      win_max <= max_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_cs_window_buffer.sv
module tb_cs_window_buffer;
  localparam int DW    = 8;
  localparam int DEPTH = 9;
  localparam int SUMW  = 12;

  logic                clk = 1'b0;
  logic                reset;
  logic                flush;
  logic                in_valid;
  logic [DW-1:0]       in_data;
  logic                in_ready;
  logic                win_valid;
  logic                win_ready;
  logic [DEPTH*DW-1:0] win_data;
  logic [SUMW-1:0]     win_sum;
  logic [15:0]         win_idx;
`ifdef CS_WINDOW_MINMAX_EN
  logic [DW-1:0]       win_min;
  logic [DW-1:0]       win_max;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cs_window_buffer #(.DW(DW), .DEPTH(DEPTH), .SUMW(SUMW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .win_valid(win_valid), .win_ready(win_ready),
    .win_data(win_data), .win_sum(win_sum),
`ifdef CS_WINDOW_MINMAX_EN
    .win_min(win_min), .win_max(win_max),
`endif
    .win_idx(win_idx)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: window as a queue of samples ---------
  typedef struct {
    logic [DEPTH*DW-1:0] data;
    int                  sum;
    int                  idx;
    int                  mn;
    int                  mx;
  } exp_t;

  logic [DW-1:0] mq[$];
  exp_t          eq[$];
  int            m_idx = 0;
  bit            pend  = 0;

  always @(posedge clk or posedge reset) begin
    bit   acc;
    exp_t e;
    if (reset) begin
      mq.delete(); eq.delete(); m_idx = 0; pend = 0;
    end else begin
      acc = in_valid && (!pend || win_ready);
      if (flush) begin
        mq.delete(); eq.delete(); pend = 0;
      end else begin
        if (pend && win_ready) begin
          void'(eq.pop_front());
          m_idx = (m_idx + 1) % 65536;
          pend = 0;
        end
        if (acc) begin
          mq.push_back(in_data);
          if (mq.size() > DEPTH) void'(mq.pop_front());
          if (mq.size() == DEPTH) begin
            e.sum = 0; e.mn = 255; e.mx = 0; e.data = '0; e.idx = m_idx;
            for (int k = 0; k < DEPTH; k++) begin
              e.data[k*DW +: DW] = mq[k];
              e.sum += mq[k];
              if (mq[k] < e.mn) e.mn = mq[k];
              if (mq[k] > e.mx) e.mx = mq[k];
            end
            eq.push_back(e);
            pend = 1;
          end
        end
      end
    end
  end

  // ---------------- monitor: compare presented window against scoreboard --
  always @(negedge clk) begin
    if (!reset) begin
      chk("win_valid", win_valid, pend);
      chk("in_ready", in_ready, !pend || win_ready);
      if (pend && win_valid) begin
        if (eq.size() == 0) begin
          checks++; errors++;
          $display("FAIL scoreboard_empty: got window expected none at %0t", $time);
        end else begin
          chk("win_data", win_data, eq[0].data);
          chk("win_sum", win_sum, eq[0].sum);
          chk("win_idx", win_idx, eq[0].idx);
`ifdef CS_WINDOW_MINMAX_EN
          chk("win_min", win_min, eq[0].mn);
          chk("win_max", win_max, eq[0].mx);
`endif
        end
      end
    end
  end

  task automatic drive(input bit v, input logic [DW-1:0] d, input bit r, input bit f);
    in_valid = v; in_data = d; win_ready = r; flush = f;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 0; in_data = 0; win_ready = 0; flush = 0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  logic [DW-1:0] rd;

  initial begin
    reset = 1'b1; flush = 0; in_valid = 0; in_data = 0; win_ready = 0;
    #2;
    chk("rst_win_valid", win_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_win_sum", win_sum, 0);
    chk("rst_win_idx", win_idx, 0);
    chk("rst_win_data", win_data, 0);
    do_reset();

    // 1: stream 1..9
    for (int i = 1; i <= 9; i++) begin
      chk("t1_no_valid_yet", win_valid, 0);
      drive(1, DW'(i), 1, 0);
    end
    chk("t1_valid", win_valid, 1);
    chk("t1_sum", win_sum, 45);
    chk("t1_slot0", win_data[0 +: DW], 1);
    chk("t1_slot8", win_data[8*DW +: DW], 9);
    chk("t1_idx", win_idx, 0);
`ifdef CS_WINDOW_MINMAX_EN
    chk("t1_min", win_min, 1);
    chk("t1_max", win_max, 9);
`endif

    // 2: sample 10, back-to-back
    drive(1, 8'd10, 1, 0);
    chk("t2_valid", win_valid, 1);
    chk("t2_sum", win_sum, 54);
    chk("t2_slot0", win_data[0 +: DW], 2);
    chk("t2_slot8", win_data[8*DW +: DW], 10);
    chk("t2_idx", win_idx, 1);

    // 3: backpressure
    do_reset();
    for (int i = 1; i <= 8; i++) drive(1, DW'(i), 1, 0);
    drive(1, 8'd9, 0, 0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_data = 8'd77; win_ready = 0; flush = 0; #1;
      chk("t3_in_ready", in_ready, 0);
      chk("t3_hold_sum", win_sum, 45);
      chk("t3_hold_idx", win_idx, 0);
      @(posedge clk); #1;
    end
    drive(1, 8'd77, 1, 0);
    chk("t3_sum", win_sum, 121);
    chk("t3_slot0", win_data[0 +: DW], 2);
    chk("t3_slot8", win_data[8*DW +: DW], 77);
    chk("t3_idx", win_idx, 1);

    // 4: maximum values
    for (int i = 0; i < 9; i++) drive(1, 8'd255, 1, 0);
    chk("t4_sum_max", win_sum, 2295);
    drive(1, 8'd255, 1, 0);
    chk("t4_sum_no_ovf", win_sum, 2295);

    // 5: flush with coincident accept after 4 samples
    drive(0, 8'd0, 1, 1);
    for (int i = 0; i < 4; i++) drive(1, 8'd3, 1, 0);
    drive(1, 8'd200, 1, 1);
    chk("t5_flushed_sum", win_sum, 0);
    for (int i = 0; i < 8; i++) begin
      drive(1, 8'd3, 1, 0);
      chk("t5_not_valid", win_valid, 0);
    end
    drive(1, 8'd3, 1, 0);
    chk("t5_valid", win_valid, 1);
    chk("t5_sum", win_sum, 27);
    chk("t5_idx_kept", win_idx, m_idx);
    chk("t5_idx_nonzero", win_idx != 0, 1);

    // 6: asynchronous reset mid-stream
    drive(1, 8'd50, 0, 0);
    #2;
    chk("t6_pre_valid", win_valid, 1);
    reset = 1'b1;
    #1;
    chk("t6_valid", win_valid, 0);
    chk("t6_sum", win_sum, 0);
    chk("t6_idx", win_idx, 0);
    chk("t6_in_ready", in_ready, 1);
    @(posedge clk); #1;
    reset = 1'b0;

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 3))
        0:       rd = 8'd0;
        1:       rd = 8'd255;
        default: rd = DW'($urandom_range(0, 255));
      endcase
      drive($urandom_range(0, 9) < 7, rd, $urandom_range(0, 9) < 6,
            $urandom_range(0, 99) < 3);
    end
    for (int n = 0; n < 4; n++) drive(0, 8'd0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule

// File: doc/cs_window_buffer.md
Name: cs_window_buffer

Overview:
- Upstream stage of the CS computational core.
- Accepts a serial stream of 8-bit samples over a valid/ready handshake.
- Keeps a sliding window of the last DEPTH samples and a running sum of them.
- Presents each full window, the sum and a window index to the CS core through a valid/ready handshake. The core then computes the average, the approximate value and the Y result.

Parameters:
- DW, 8, sample width in bits.
- DEPTH, 9, window length in samples.
- SUMW, 12, running-sum width; must satisfy 2^SUMW > DEPTH*(2^DW-1), i.e. 2295 < 4096 at defaults.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of window contents, sum and fill count.
- in_valid  input  1  in_data holds a sample.
- in_data  input  DW  sample value, unsigned.
- in_ready  output  1  block can accept a sample this cycle.
- win_valid  output  1  win_data, win_sum and win_idx hold a complete window.
- win_ready  input  1  consumer accepts the window this cycle.
- win_data  output  DEPTH*DW  window contents; slice k (bits k*DW+:DW) is the k-th oldest sample, slot DEPTH-1 is the newest.
- win_sum  output  SUMW  exact unsigned sum of all DEPTH slots.
- win_idx  output  16  number of windows emitted before this one, wrapping mod 2^16.

Behaviour:
- Reset (async):
  - all window slots, win_sum, win_idx and the fill count go to 0.
  - win_valid goes to 0; in_ready goes to 1.
- Accept: in_valid && in_ready at a rising edge.
- in_ready = !win_valid || win_ready (combinational). A sample can be accepted in the same cycle the held window is consumed.
- On accept:
  - slots shift down one position (slot k <= slot k+1); slot DEPTH-1 <= in_data.
  - win_sum <= win_sum + in_data - slot0 when fill == DEPTH; otherwise win_sum <= win_sum + in_data.
  - fill <= min(fill+1, DEPTH).
- Fill states:
  - EMPTY/FILLING: fill < DEPTH, win_valid = 0.
  - FULL: fill == DEPTH; every further accept produces a new window.
- win_valid:
  - is set on the edge of any accept that leaves fill == DEPTH. Latency: window visible 1 cycle after the completing sample is accepted.
  - is cleared on a win_ready edge with no simultaneous accept.
  - if win_ready and an accept coincide, win_valid stays 1 and the outputs update to the next window. Back-to-back throughput is 1 window per cycle.
- Output stability: while win_valid && !win_ready, win_data, win_sum and win_idx are held and no sample is accepted (in_ready = 0).
- win_idx increments on every win_valid && win_ready edge, wrapping 65535 -> 0.
- Sum arithmetic:
  - unsigned, full SUMW width.
  - the subtract of the oldest sample happens in the same cycle as the add, so there is never an intermediate overflow.
- flush:
  - takes effect on the next edge: slots, win_sum and fill <= 0; win_valid <= 0.
  - win_idx is retained.
  - flush has priority over a simultaneous accept (that sample is dropped) and over a simultaneous window consume.
- Reset mid-operation: immediate return to reset values regardless of state; any partial window is discarded.
- in_valid while in_ready = 0: the sample is not taken; the producer must hold it.

Optional Feature:
- Macro: CS_WINDOW_MINMAX_EN
- When defined:
  - adds outputs win_min (DW) and win_max (DW), registered, updated in the same edge as the window slots.
  - values are the minimum and maximum over the DEPTH slots of the new window, so they are valid exactly when win_valid = 1.
  - both reset to 0 and flush to 0.
- When undefined: the ports and the logic are absent; all other behaviour is identical.

Test Plan:
1. Reset, then stream 1..9 with win_ready = 1:
   - win_valid rises 1 cycle after sample 9 is accepted.
   - win_sum = 45, slot0 = 1, slot8 = 9, win_idx = 0.
   - with the macro: win_min = 1, win_max = 9.
2. Continue with sample 10:
   - window = 2..10, win_sum = 54, win_idx = 1.
   - back-to-back: win_valid stays 1 with no gap cycle.
3. Backpressure: window 1..9 valid, hold win_ready = 0 for 5 cycles with in_valid = 1, in_data = 77:
   - in_ready = 0 and outputs are stable.
   - release win_ready: window 2..9,77 appears next cycle, win_sum = 121.
4. Max values: stream nine samples of 255:
   - win_sum = 2295.
   - one more 255: win_sum remains 2295, no overflow.
5. Assert flush with a coincident accept after 4 samples:
   - fill restarts; the coincident sample is dropped.
   - 9 new samples of 3 are needed before win_valid rises; win_sum = 27.
   - win_idx continues from its prior value.
6. Assert reset asynchronously mid-stream with win_valid = 1:
   - win_valid = 0 and win_sum = 0 immediately, without a clock edge.
   - win_idx = 0; in_ready = 1.
